wb_merge_buffer: RTL

WB_MERGE_BUFFER -- requirements
Module: wb_merge_buffer

---
 rtl/wb_merge_buffer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/wb_merge_buffer.sv
// wb_merge_buffer: merges the single-cycle ALU result stream and the multi-cycle
// unit result stream into one registered writeback port, buffering overflow in a
// small FIFO so that results leave strictly oldest-first.
// Latency: 1 cycle from acceptance to wbPacket_o when the FIFO is empty; 1 packet/cycle out.
// Backpressure: the ALU is never stalled; the MC unit is held off via mcReady_o.
// Ports:
//    clk, reset          rising-edge clock, synchronous active-high reset
//    flush_i             discard everything held and arriving this cycle
//    aluPacket_i         ALU result, always accepted when valid
//    mcPacket_i          MC result, accepted when valid && mcReady_o
//    mcReady_o           MC acceptance, from registered count and ALU valid only
//    wbPacket_o          registered merged writeback packet
//    count_o             registered FIFO occupancy

package wb_merge_buffer_pkg;
   typedef struct packed {
      logic [9:0]  seqNo;
      logic [3:0]  flags;
      logic [4:0]  logDest;
      logic [6:0]  phyDest;
      logic [31:0] destData;
      logic [5:0]  alID;
      logic        valid;
   } wbPkt;
endpackage

module wb_merge_buffer
   import wb_merge_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush_i,
   input  wbPkt                       aluPacket_i,
   input  wbPkt                       mcPacket_i,
   output logic                       mcReady_o,
   output wbPkt                       wbPacket_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int          PW      = $clog2(DEPTH);
   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [31:0] DEPTH_U = DEPTH;

   wbPkt          mem [DEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q, count_d;
   wbPkt          wb_q, nxt_out;

   logic          alu_acc, mc_acc, pop;
   logic          wr0_en, wr1_en;
   wbPkt          wr0_dat, wr1_dat;
   logic [1:0]    n_push;

   // Readiness deliberately ignores the same-cycle dequeue and flush so the
   // path from the pop decision back to the MC unit stays short.
   always_comb begin
      mcReady_o = ((32'(count_q) + 32'(aluPacket_i.valid)) < DEPTH_U);
      alu_acc   = aluPacket_i.valid & ~flush_i;
      mc_acc    = mcPacket_i.valid & mcReady_o & ~flush_i;
   end

   // Age order: FIFO head, then ALU, then MC. The oldest goes to the output
   // register; whatever remains is pushed in that same order.
   always_comb begin
      nxt_out = '0;
      pop     = 1'b0;
      wr0_en  = 1'b0;
      wr0_dat = aluPacket_i;
      wr1_en  = 1'b0;
      wr1_dat = mcPacket_i;
      if (count_q != '0) begin
         nxt_out = mem[head_q];
         pop     = 1'b1;
         if (alu_acc) begin
            wr0_en = 1'b1;
            wr1_en = mc_acc;
         end else if (mc_acc) begin
            wr0_en  = 1'b1;
            wr0_dat = mcPacket_i;
         end
      end else if (alu_acc) begin
         nxt_out = aluPacket_i;
         wr0_en  = mc_acc;
         wr0_dat = mcPacket_i;
      end else if (mc_acc) begin
         nxt_out = mcPacket_i;
      end
      n_push  = {1'b0, wr0_en} + {1'b0, wr1_en};
      count_d = count_q + CW'(n_push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         wb_q    <= '0;
      end else if (flush_i) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         wb_q    <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_q + PW'(pop);
         tail_q  <= tail_q + PW'(n_push);
         wb_q    <= nxt_out;
      end
   end

   // Storage has no reset; occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (wr0_en) mem[tail_q] <= wr0_dat;
         if (wr1_en) mem[tail_q + PW'(1)] <= wr1_dat;
      end
   end

   assign wbPacket_o = wb_q;
   assign count_o    = count_q;

endmodule
